// File: rtl/display_scan_controller.sv
// Reaction-time display front end: binary-to-BCD conversion, leading-zero blanking,
// and two-channel digit multiplexing toward the segment encoder.
module display_scan_controller #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned BIN_W    = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [BIN_W-1:0] value,
   input  logic             blank_all,
   output logic             busy,
   output logic             overflow,
   output logic [3:0]       data_1,
   output logic [3:0]       data_2,
   output logic [1:0]       dig_sel
);

   localparam int unsigned BCD_W  = 16;
   localparam int unsigned SR_W   = BCD_W + BIN_W;
   localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
   localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [3:0]  BLANK  = 4'd10;
   localparam logic [31:0] MAX_DISP = 32'd9999;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t           state;
   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  sr_adj;
   logic [CNT_W-1:0] bit_cnt;
   logic [3:0]       d3, d2, d1, d0;
   logic [3:0]       thou, hund, tens, ones;
   logic [SCAN_W-1:0] scan_cnt;
   logic             phase;

   // Add 3 to every BCD nibble that is 5 or more, ahead of the next doubling.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (b[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   always_comb begin
      sr_adj = sr;
      sr_adj[SR_W-1 -: BCD_W] = add3(sr[SR_W-1 -: BCD_W]);
   end

   assign thou = sr[SR_W-1  -: 4];
   assign hund = sr[SR_W-5  -: 4];
   assign tens = sr[SR_W-9  -: 4];
   assign ones = sr[SR_W-13 -: 4];

   // Conversion FSM; the shift register holds {bcd, bin} and the display
   // digits change only in COMMIT so the old value stays up meanwhile.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         overflow <= 1'b0;
         sr       <= '0;
         bit_cnt  <= '0;
         d3       <= BLANK;
         d2       <= BLANK;
         d1       <= BLANK;
         d0       <= BLANK;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  if (32'(value) > MAX_DISP) begin
                     sr       <= {BCD_W'(0), BIN_W'(MAX_DISP)};
                     overflow <= 1'b1;
                  end else begin
                     sr       <= {BCD_W'(0), value};
                     overflow <= 1'b0;
                  end
                  bit_cnt <= CNT_W'(BIN_W);
                  busy    <= 1'b1;
                  state   <= CONV;
               end
            end
            CONV: begin
               sr      <= sr_adj << 1;
               bit_cnt <= bit_cnt - CNT_W'(1);
               if (bit_cnt == CNT_W'(1)) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               d3    <= (thou == 4'd0) ? BLANK : thou;
               d2    <= (thou == 4'd0 && hund == 4'd0) ? BLANK : hund;
               d1    <= (thou == 4'd0 && hund == 4'd0 && tens == 4'd0) ? BLANK : tens;
               d0    <= ones;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Free-running scan divider; phase flips on every wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         phase    <= 1'b0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         phase    <= ~phase;
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   // Output stage: phase 0 drives d3/d1, phase 1 drives d2/d0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig_sel <= 2'b01;
         data_1  <= BLANK;
         data_2  <= BLANK;
      end else begin
         dig_sel <= phase ? 2'b10 : 2'b01;
         if (blank_all) begin
            data_1 <= BLANK;
            data_2 <= BLANK;
         end else if (phase) begin
            data_1 <= d2;
            data_2 <= d0;
         end else begin
            data_1 <= d3;
            data_2 <= d1;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed, table-driven bench for display_scan_controller with a short scan divider.
module tb_display_scan_controller;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned BIN_W    = 14;
   localparam int          NVEC     = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             load;
   logic [BIN_W-1:0] value;
   logic             blank_all;
   logic             busy;
   logic             overflow;
   logic [3:0]       data_1;
   logic [3:0]       data_2;
   logic [1:0]       dig_sel;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int value;
      int ovf;
      int d3;
      int d2;
      int d1;
      int d0;
   } vec_t;

   vec_t vecs [NVEC];

   always #5 clk = ~clk;

   display_scan_controller #(.SCAN_DIV(SCAN_DIV), .BIN_W(BIN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .value     (value),
      .blank_all (blank_all),
      .busy      (busy),
      .overflow  (overflow),
      .data_1    (data_1),
      .data_2    (data_2),
      .dig_sel   (dig_sel)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_sel(input logic [1:0] s);
      int n;
      n = 0;
      while (dig_sel !== s && n < 20) begin
         tick();
         n++;
      end
      chk("dig_sel_reach", int'(dig_sel), int'(s));
   endtask

   // Waits past the commit-to-output latency, then checks both scan phases.
   task automatic check_disp(input string tag, input int d3, input int d2,
                             input int d1, input int d0);
      tick();
      wait_sel(2'b01);
      chk({tag, "_p0_data_1"}, int'(data_1), d3);
      chk({tag, "_p0_data_2"}, int'(data_2), d1);
      wait_sel(2'b10);
      chk({tag, "_p1_data_1"}, int'(data_1), d2);
      chk({tag, "_p1_data_2"}, int'(data_2), d0);
   endtask

   task automatic do_load(input int v, output int busy_cycles);
      value = BIN_W'(v);
      load  = 1'b1;
      tick();
      load  = 1'b0;
      busy_cycles = 0;
      while (busy && busy_cycles < 100) begin
         busy_cycles++;
         tick();
      end
   endtask

   initial begin
      int  n;
      int  bad;
      int  seen01;
      int  seen10;
      logic [1:0] s;

      vecs[0] = '{1234,  0, 1,  2,  3,  4};
      vecs[1] = '{7,     0, 10, 10, 10, 7};
      vecs[2] = '{0,     0, 10, 10, 10, 0};
      vecs[3] = '{12000, 1, 9,  9,  9,  9};
      vecs[4] = '{305,   0, 10, 3,  0,  5};
      vecs[5] = '{9999,  0, 9,  9,  9,  9};
      vecs[6] = '{10000, 1, 9,  9,  9,  9};
      vecs[7] = '{16383, 1, 9,  9,  9,  9};
      vecs[8] = '{50,    0, 10, 10, 5,  0};
      vecs[9] = '{1000,  0, 1,  0,  0,  0};

      rst = 1'b1;
      load = 1'b0;
      blank_all = 1'b0;
      value = '0;
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_data_1", int'(data_1), 10);
      chk("rst_data_2", int'(data_2), 10);
      chk("rst_dig_sel", int'(dig_sel), 1);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_blank", int'(data_1) * 16 + int'(data_2), 10 * 16 + 10);

      // Scan period: dig_sel must hold for SCAN_DIV cycles between toggles.
      s = dig_sel;
      n = 0;
      while (dig_sel == s && n < 20) begin tick(); n++; end
      s = dig_sel;
      n = 0;
      while (dig_sel == s && n < 20) begin tick(); n++; end
      chk("scan_period", n, SCAN_DIV);

      for (int i = 0; i < NVEC; i++) begin
         do_load(vecs[i].value, n);
         chk($sformatf("v%0d_busy_len", vecs[i].value), n, BIN_W + 1);
         chk($sformatf("v%0d_overflow", vecs[i].value), int'(overflow), vecs[i].ovf);
         check_disp($sformatf("v%0d", vecs[i].value),
                    vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0);
      end

      // Loads while busy (mid-conversion and on the COMMIT edge) are ignored.
      value = BIN_W'(4321);
      load  = 1'b1;
      tick();
      n = 0;
      while (busy && n < 100) begin
         n++;
         load  = (n == 5 || n == 15);
         value = (n == 5) ? BIN_W'(99) : ((n == 15) ? BIN_W'(12000) : BIN_W'(4321));
         tick();
      end
      load = 1'b0;
      chk("busy_load_len", n, BIN_W + 1);
      tick();
      chk("busy_load_no_restart", int'(busy), 0);
      chk("busy_load_overflow", int'(overflow), 0);
      check_disp("v4321", 4, 3, 2, 1);

      // Reset during conversion blanks the display and clears overflow.
      do_load(12000, n);
      check_disp("pre_abort", 9, 9, 9, 9);
      value = BIN_W'(5555);
      load  = 1'b1;
      tick();
      load  = 1'b0;
      repeat (6) tick();
      chk("abort_busy_before", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_overflow", int'(overflow), 0);
      chk("abort_data_1", int'(data_1), 10);
      chk("abort_data_2", int'(data_2), 10);
      chk("abort_dig_sel", int'(dig_sel), 1);
      tick();
      tick();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (data_1 != 4'd10 || data_2 != 4'd10 || busy) bad++;
      end
      chk("abort_stays_blank", bad, 0);
      do_load(5555, n);
      chk("v5555_busy_len", n, BIN_W + 1);
      check_disp("v5555", 5, 5, 5, 5);

      // blank_all forces blanks next edge while the scan continues.
      do_load(1234, n);
      check_disp("pre_blank", 1, 2, 3, 4);
      blank_all = 1'b1;
      tick();
      chk("blank_data_1", int'(data_1), 10);
      chk("blank_data_2", int'(data_2), 10);
      bad = 0;
      seen01 = 0;
      seen10 = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (data_1 != 4'd10 || data_2 != 4'd10) bad++;
         if (dig_sel == 2'b01) seen01 = 1;
         if (dig_sel == 2'b10) seen10 = 1;
      end
      chk("blank_hold", bad, 0);
      chk("blank_scan_toggles", seen01 + seen10, 2);
      blank_all = 1'b0;
      tick();
      if (dig_sel == 2'b01) begin
         chk("unblank_data_1", int'(data_1), 1);
         chk("unblank_data_2", int'(data_2), 3);
      end else begin
         chk("unblank_data_1", int'(data_1), 2);
         chk("unblank_data_2", int'(data_2), 4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
